// File: rtl/symbol_upsampler.sv
// Symbol upsampler: expands each accepted {I,Q} symbol into sps_q output
// samples, either zero-stuffed (symbol on phase 0, zeros after) or
// sample-and-hold (symbol on every phase). Feeds the pulse-shaping filter.
//
// Handshake: a transfer happens on a rising clk_bb edge where valid and ready
// are both high. A producer holds valid and its payload until that edge, and
// ready never depends on the same side's valid. in_ready may depend on
// out_ready, so a new symbol is taken on the same edge as the last sample of
// the previous one and the output stream has no gap.
//
// The two-state FSM is visible on st_busy (high exactly in EXPAND).
module symbol_upsampler #(
   parameter int MAX_SPS = 16,
   parameter int SPS_W   = 7
) (
   input  logic             clk_bb,
   input  logic             rst,
   input  logic             cfg_enable,
   input  logic             cfg_hold,
   input  logic [SPS_W-1:0] cfg_sps,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             out_last,
   output logic             st_busy,
   output logic [15:0]      st_sym_count
);

   // Wide enough to hold MAX_SPS itself (the phase counter never exceeds MAX_SPS-1).
   localparam int CNT_W = $clog2(MAX_SPS + 1);

   typedef enum logic {
      IDLE   = 1'b0,
      EXPAND = 1'b1
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] phase, phase_n;
   logic [CNT_W-1:0] sps_q, sps_n;
   logic [CNT_W-1:0] sps_eff;
   logic [31:0]      sym, sym_n;
   logic             sym_last, sym_last_n;
   logic [15:0]      count, count_n;
   logic [31:0]      sps_wide;
   logic             last_phase;
   logic             expanding;
   logic             out_fire;
   logic             accept;

   // Clamp the requested samples-per-symbol into 1..MAX_SPS.
   always_comb begin
      sps_wide = 32'(cfg_sps);
      if (sps_wide <= 32'd1) begin
         sps_eff = CNT_W'(1);
      end else if (sps_wide > 32'(MAX_SPS)) begin
         sps_eff = CNT_W'(MAX_SPS);
      end else begin
         sps_eff = CNT_W'(sps_wide);
      end
   end

   // Handshake and output decode; everything is forced low while rst is high.
   always_comb begin
      expanding  = (state == EXPAND);
      last_phase = (phase == (sps_q - CNT_W'(1)));
      out_valid  = ~rst & expanding;
      in_ready   = ~rst & cfg_enable & (~expanding | (out_ready & last_phase));
      out_fire   = out_valid & out_ready;
      accept     = in_valid & in_ready;
      out_last   = out_valid & sym_last & last_phase;
      st_busy    = out_valid;
      out_data   = 32'h0;
      if (out_valid && ((phase == '0) || cfg_hold)) begin
         out_data = sym;
      end
      st_sym_count = count;
   end

   // Next-state logic: accept a symbol, step the phase, count completed symbols.
   always_comb begin
      state_n    = state;
      phase_n    = phase;
      sps_n      = sps_q;
      sym_n      = sym;
      sym_last_n = sym_last;
      count_n    = count;
      if (out_fire) begin
         if (last_phase) begin
            state_n = IDLE;
            phase_n = '0;
            count_n = count + 16'd1;
         end else begin
            phase_n = phase + CNT_W'(1);
         end
      end
      // A new symbol wins over the return to IDLE on the same edge.
      if (accept) begin
         state_n    = EXPAND;
         phase_n    = '0;
         sps_n      = sps_eff;
         sym_n      = in_data;
         sym_last_n = in_last;
      end
   end

   // State registers with synchronous reset; reset drops any held symbol.
   always_ff @(posedge clk_bb) begin
      if (rst) begin
         state    <= IDLE;
         phase    <= '0;
         sps_q    <= CNT_W'(1);
         sym      <= 32'h0;
         sym_last <= 1'b0;
         count    <= 16'h0;
      end else begin
         state    <= state_n;
         phase    <= phase_n;
         sps_q    <= sps_n;
         sym      <= sym_n;
         sym_last <= sym_last_n;
         count    <= count_n;
      end
   end

endmodule
